// File: rtl/ntt_host_ctrl.sv
// Host-side job sequencer for the FFT/NTT user project: command beat, operand load, result drain, status poll, re-arm write.
// Latency: command beat visible the cycle after start; LOAD/DRAIN are zero-latency combinational pass-throughs at one beat per cycle.
// Backpressure: stream readies pass straight through in LOAD/DRAIN and are held low elsewhere; AXI-Lite valids hold until accepted.
// Optional checksum output is compiled in with NTT_HOST_CTRL_CHECKSUM_EN.
module ntt_host_ctrl #(
   parameter int pIN_WORDS = 2048,
   parameter int pPOLL_MAX = 255
) (
   input  logic        axi_clk,
   input  logic        axi_reset_n,
   input  logic        start,
   input  logic [1:0]  mode,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [2:0]  state_o,
   output logic [11:0] out_cnt,
   input  logic        src_tvalid,
   input  logic [31:0] src_tdata,
   output logic        src_tready,
   output logic        ss_tvalid,
   output logic [31:0] ss_tdata,
   output logic        ss_tlast,
   input  logic        ss_tready,
   input  logic        sm_tvalid,
   input  logic [31:0] sm_tdata,
   input  logic        sm_tlast,
   output logic        sm_tready,
   output logic        dst_tvalid,
   output logic [31:0] dst_tdata,
   input  logic        dst_tready,
   output logic        awvalid,
   output logic [11:0] awaddr,
   input  logic        awready,
   output logic        wvalid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic        wready,
   output logic        arvalid,
   output logic [11:0] araddr,
   input  logic        arready,
   input  logic        rvalid,
   input  logic [31:0] rdata,
   output logic        rready
`ifdef NTT_HOST_CTRL_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_LOAD    = 3'd2,
      S_DRAIN   = 3'd3,
      S_POLL_AR = 3'd4,
      S_POLL_R  = 3'd5,
      S_RST_W   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   localparam logic [11:0] LAST_IN   = 12'(pIN_WORDS - 1);
   localparam logic [11:0] POLL_LAST = 12'(pPOLL_MAX - 1);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  mode_q;
   logic [11:0] in_cnt;
   logic [11:0] poll_cnt;
   logic [11:0] drain_last;
   logic        job_start;
   logic        load_hs;
   logic        drain_hs;
   logic        poll_miss;
   logic        unused_rdata;

   // Only the ready bit of the status word matters.
   assign unused_rdata = ^rdata[31:1];

   // Mode 2/3 jobs return half the result count.
   assign drain_last = mode_q[1] ? 12'd1023 : 12'd2047;

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign state_o = state;
   assign awaddr  = 12'h000;
   assign araddr  = 12'h000;

   // State register; reset drops every valid at once because outputs decode from it.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and decoded outputs, including the LOAD/DRAIN stream pass-throughs.
   always_comb begin
      state_nxt  = state;
      job_start  = 1'b0;
      load_hs    = 1'b0;
      drain_hs   = 1'b0;
      poll_miss  = 1'b0;
      src_tready = 1'b0;
      ss_tvalid  = 1'b0;
      ss_tdata   = 32'h0;
      ss_tlast   = 1'b0;
      sm_tready  = 1'b0;
      dst_tvalid = 1'b0;
      dst_tdata  = 32'h0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wdata      = 32'h0;
      wstrb      = 4'h0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               job_start = 1'b1;
               state_nxt = S_CMD;
            end
         end
         S_CMD: begin
            ss_tvalid = 1'b1;
            ss_tdata  = {28'b0, 2'b01, mode_q};
            if (ss_tready) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            ss_tvalid  = src_tvalid;
            ss_tdata   = src_tdata;
            src_tready = ss_tready;
            ss_tlast   = (in_cnt == LAST_IN);
            load_hs    = src_tvalid & ss_tready;
            if (load_hs && in_cnt == LAST_IN) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            sm_tready  = dst_tready;
            dst_tvalid = sm_tvalid;
            dst_tdata  = sm_tdata;
            drain_hs   = sm_tvalid & dst_tready;
            if (drain_hs && out_cnt == drain_last) state_nxt = S_POLL_AR;
         end
         S_POLL_AR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = S_POLL_R;
         end
         S_POLL_R: begin
            rready = 1'b1;
            if (rvalid) begin
               if (rdata[0]) begin
                  state_nxt = S_RST_W;
               end else begin
                  poll_miss = 1'b1;
                  state_nxt = (poll_cnt == POLL_LAST) ? S_DONE : S_POLL_AR;
               end
            end
         end
         S_RST_W: begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            wdata   = 32'h1;
            wstrb   = 4'hF;
            if (awready && wready) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Job context, beat counters and the sticky error flag.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         mode_q   <= 2'b00;
         err      <= 1'b0;
         out_cnt  <= 12'h0;
         in_cnt   <= 12'h0;
         poll_cnt <= 12'h0;
      end else begin
         if (job_start) begin
            mode_q   <= mode;
            err      <= 1'b0;
            out_cnt  <= 12'h0;
            in_cnt   <= 12'h0;
            poll_cnt <= 12'h0;
         end
         if (load_hs) in_cnt <= in_cnt + 12'd1;
         if (drain_hs) begin
            out_cnt <= out_cnt + 12'd1;
            if (sm_tlast != (out_cnt == drain_last)) err <= 1'b1;
         end
         if (poll_miss) begin
            poll_cnt <= poll_cnt + 12'd1;
            if (poll_cnt == POLL_LAST) err <= 1'b1;
         end
      end
   end

`ifdef NTT_HOST_CTRL_CHECKSUM_EN
   // XOR of every accepted result word; kept after done for the host to read.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         checksum <= 32'h0;
      end else if (job_start) begin
         checksum <= 32'h0;
      end else if (drain_hs) begin
         checksum <= checksum ^ sm_tdata;
      end
   end
`endif

endmodule

// File: tb/tb_ntt_host_ctrl.sv
`timescale 1ns/1ps
module tb_ntt_host_ctrl;
   localparam int IN_WORDS = 2048;
   localparam int POLL_MAX = 3;

   logic        axi_clk = 1'b0;
   logic        axi_reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        busy, done, err;
   logic [2:0]  state_o;
   logic [11:0] out_cnt;
   logic        src_tvalid = 1'b0;
   logic [31:0] src_tdata = 32'h0;
   logic        src_tready;
   logic        ss_tvalid, ss_tlast;
   logic [31:0] ss_tdata;
   logic        ss_tready = 1'b0;
   logic        sm_tvalid = 1'b0, sm_tlast = 1'b0;
   logic [31:0] sm_tdata = 32'h0;
   logic        sm_tready;
   logic        dst_tvalid;
   logic [31:0] dst_tdata;
   logic        dst_tready = 1'b0;
   logic        awvalid, wvalid, arvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
`ifdef NTT_HOST_CTRL_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   always #5 axi_clk = ~axi_clk;

   ntt_host_ctrl #(.pIN_WORDS(IN_WORDS), .pPOLL_MAX(POLL_MAX)) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start), .mode(mode),
      .busy(busy), .done(done), .err(err), .state_o(state_o), .out_cnt(out_cnt),
      .src_tvalid(src_tvalid), .src_tdata(src_tdata), .src_tready(src_tready),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
      .dst_tvalid(dst_tvalid), .dst_tdata(dst_tdata), .dst_tready(dst_tready),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready)
`ifdef NTT_HOST_CTRL_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   int total = 0;
   int bad = 0;

   // Model state: what the job must look like, kept as plain queues and counts.
   logic [31:0] src_q[$];
   logic [32:0] exp_ss_q[$];
   logic [32:0] sm_q[$];
   logic [31:0] exp_dst_q[$];
   int  ss_seen, dst_seen, n_reads, n_writes, n_done;
   int  exp_e, exp_reads, exp_writes, exp_left, ok_at;
   bit  exp_err, job_active, rd_pend;
   int  src_pct = 100, ss_pct = 100, sm_pct = 100, dst_pct = 100, axi_pct = 100;
   logic [31:0] model_csum, first_cmd;
   logic hs_ss, hs_dst, hs_src, hs_sm, hs_ar, hs_r, hs_w, in_load, in_drain;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(99) < p;
   endfunction

   // Input driver: operands, project results, AXI-Lite responder, readies.
   initial forever begin
      logic [31:0] junk;
      @(posedge axi_clk);
      #1;
      src_tvalid = (src_q.size() > 0) && pct(src_pct);
      src_tdata  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      sm_tvalid  = (sm_q.size() > 0) && pct(sm_pct);
      {sm_tlast, sm_tdata} = (sm_q.size() > 0) ? sm_q[0] : 33'h0;
      ss_tready  = pct(ss_pct);
      dst_tready = pct(dst_pct);
      arready    = !rd_pend && pct(axi_pct);
      rvalid     = rd_pend && pct(axi_pct);
      junk       = $urandom();
      rdata      = {junk[31:1], (ok_at >= 0 && n_reads == ok_at)};
      awready    = pct(axi_pct);
      wready     = pct(axi_pct);
   end

   // Compare process: every beat against the model, plus the per-cycle gating rules.
   initial forever begin
      @(negedge axi_clk);
      hs_ss  = ss_tvalid && ss_tready;
      hs_dst = dst_tvalid && dst_tready;
      hs_src = src_tvalid && src_tready;
      hs_sm  = sm_tvalid && sm_tready;
      hs_ar  = arvalid && arready;
      hs_r   = rvalid && rready;
      hs_w   = awvalid && awready && wvalid && wready;
      in_load  = job_active && ss_seen >= 1 && ss_seen <= IN_WORDS;
      in_drain = job_active && ss_seen == IN_WORDS + 1 && dst_seen < exp_e;
      if (hs_ss) begin
         if (ss_seen == 0) first_cmd = ss_tdata;
         if (exp_ss_q.size() == 0) chk("ss_extra_beat", {ss_tlast, ss_tdata}, 64'hDEAD);
         else chk("ss_beat", {ss_tlast, ss_tdata}, exp_ss_q.pop_front());
      end
      if (hs_dst) begin
         if (exp_dst_q.size() == 0) chk("dst_extra_beat", dst_tdata, 64'hDEAD);
         else begin
            model_csum = model_csum ^ exp_dst_q[0];
            chk("dst_beat", dst_tdata, exp_dst_q.pop_front());
         end
      end
      if (job_active) begin
         chk("src_tready_gate", src_tready, in_load ? ss_tready : 1'b0);
         chk("sm_tready_gate", sm_tready, in_drain ? dst_tready : 1'b0);
         chk("dst_tvalid_gate", dst_tvalid, in_drain ? sm_tvalid : 1'b0);
         if (in_load) chk("ss_tvalid_pass", ss_tvalid, src_tvalid);
         if (ss_seen >= 1) chk("out_cnt_live", out_cnt, dst_seen);
      end
      if (arvalid) chk("araddr", araddr, 0);
      chk("aw_w_pair", awvalid, wvalid);
      if (awvalid) chk("aw_w_fields", {awaddr, wdata, wstrb}, {12'h000, 32'h1, 4'hF});
      if (hs_src) void'(src_q.pop_front());
      if (hs_sm) void'(sm_q.pop_front());
      if (hs_ss) ss_seen++;
      if (hs_dst) dst_seen++;
      if (hs_ar) rd_pend = 1;
      if (hs_r) begin rd_pend = 0; n_reads++; end
      if (hs_w) n_writes++;
      if (done) n_done++;
   end

   // Build the expected job from the rules: command word, operands, E results, poll outcome.
   task automatic setup_job(input logic [1:0] m, input int tag, input int tlast_at,
                            input int n_res, input int ok, input bit csum_pat);
      logic [31:0] w;
      bit last;
      src_q.delete(); exp_ss_q.delete(); sm_q.delete(); exp_dst_q.delete();
      exp_ss_q.push_back({1'b0, 28'b0, 2'b01, m});
      for (int i = 0; i < IN_WORDS; i++) begin
         w = 32'hA000_0000 + (32'(tag) << 16) + 32'(i);
         src_q.push_back(w);
         exp_ss_q.push_back({(i == IN_WORDS - 1), w});
      end
      exp_e = m[1] ? 1024 : 2048;
      exp_err = 0;
      for (int i = 0; i < n_res; i++) begin
         if (csum_pat) w = (i < 3) ? (32'h1 << i) : 32'h0;
         else w = 32'h5000_0000 ^ (32'(tag) << 20) ^ (32'(i) * 32'h9E37);
         last = (i == tlast_at);
         sm_q.push_back({last, w});
         if (i < exp_e) begin
            exp_dst_q.push_back(w);
            if (last != (i == exp_e - 1)) exp_err = 1;
         end
      end
      exp_left   = n_res - exp_e;
      ok_at      = ok;
      exp_reads  = (ok >= 0 && ok < POLL_MAX) ? ok + 1 : POLL_MAX;
      exp_writes = (ok >= 0 && ok < POLL_MAX) ? 1 : 0;
      if (exp_writes == 0) exp_err = 1;
      ss_seen = 0; dst_seen = 0; n_reads = 0; n_writes = 0; n_done = 0;
      model_csum = 32'h0;
   endtask

   task automatic start_job(input logic [1:0] m);
      @(posedge axi_clk);
      #1;
      mode = m; start = 1'b1; job_active = 1;
      @(posedge axi_clk);
      #1;
      start = 1'b0; mode = ~m;
   endtask

   task automatic finish_job(input string nm);
      int cyc = 0;
      while (n_done == 0 && cyc < 30000) begin
         @(negedge axi_clk);
         cyc++;
         if (cyc == 100) start = 1'b1;
         if (cyc == 101) start = 1'b0;
      end
      if (n_done == 0) chk({nm, "_done_timeout"}, cyc, 0);
      repeat (3) @(negedge axi_clk);
      #1;
      job_active = 0;
      chk({nm, "_done_pulses"}, n_done, 1);
      chk({nm, "_err"}, err, exp_err);
      chk({nm, "_out_cnt"}, out_cnt, exp_e);
      chk({nm, "_beats"}, {32'(ss_seen), 32'(dst_seen)}, {32'(IN_WORDS + 1), 32'(exp_e)});
      chk({nm, "_reads"}, n_reads, exp_reads);
      chk({nm, "_writes"}, n_writes, exp_writes);
      chk({nm, "_idle"}, {busy, state_o}, 4'h0);
      chk({nm, "_queues_empty"}, exp_ss_q.size() + exp_dst_q.size(), 0);
      chk({nm, "_results_left"}, sm_q.size(), exp_left);
`ifdef NTT_HOST_CTRL_CHECKSUM_EN
      chk({nm, "_checksum"}, checksum, model_csum);
`endif
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_ctl"}, {busy, done, err, state_o}, 6'h0);
      chk({nm, "_out_cnt"}, out_cnt, 0);
      chk({nm, "_stream"}, {ss_tvalid, ss_tlast, src_tready, sm_tready, dst_tvalid}, 5'h0);
      chk({nm, "_axil_vld"}, {awvalid, wvalid, arvalid, rready}, 4'h0);
      chk({nm, "_axil_dat"}, {awaddr, araddr, wdata, wstrb}, 60'h0);
      chk({nm, "_ss_tdata"}, ss_tdata, 0);
`ifdef NTT_HOST_CTRL_CHECKSUM_EN
      chk({nm, "_checksum"}, checksum, 0);
`endif
   endtask

   initial begin
      int cyc;
      ok_at = -1; job_active = 0; rd_pend = 0;
      ss_seen = 0; dst_seen = 0; n_reads = 0; n_writes = 0; n_done = 0; exp_e = 2048;
      sm_q.push_back({1'b0, 32'h1234_5678});
      repeat (3) @(negedge axi_clk);
      check_reset("reset");
      @(posedge axi_clk);
      #1;
      axi_reset_n = 1'b1;

      // Mode 0, all ready, status ready on first read.
      setup_job(2'd0, 1, 2047, 2048, 0, 0);
      start_job(2'd0);
      finish_job("m0");
      chk("m0_cmd_word", first_cmd, 32'h4);
      chk("m0_out_cnt_lit", out_cnt, 12'd2048);

      // Mode 2: 1024 results, status ready on second read.
      setup_job(2'd2, 2, 1023, 1024, 1, 0);
      start_job(2'd2);
      finish_job("m2");
      chk("m2_cmd_word", first_cmd, 32'h6);
      chk("m2_out_cnt_lit", out_cnt, 12'd1024);

      // Mode 2 fed 2048 results: only 1024 accepted, the rest stall.
      setup_job(2'd2, 3, 2047, 2048, 0, 0);
      start_job(2'd2);
      finish_job("m2_stall");
      chk("m2_stall_left_lit", sm_q.size(), 1024);

      // Mode 0 with tlast on beat 1000.
      setup_job(2'd0, 4, 1000, 2048, 0, 0);
      start_job(2'd0);
      finish_job("bad_tlast");
      chk("bad_tlast_err_lit", err, 1'b1);

      // Random backpressure on every channel.
      src_pct = 70; ss_pct = 50; sm_pct = 80; dst_pct = 50; axi_pct = 50;
      setup_job(2'd1, 5, 2047, 2048, 2, 0);
      start_job(2'd1);
      finish_job("bp");
      src_pct = 100; ss_pct = 100; sm_pct = 100; dst_pct = 100; axi_pct = 100;

      // Status never ready: exactly POLL_MAX reads, no write.
      setup_job(2'd3, 6, 1023, 1024, -1, 0);
      start_job(2'd3);
      finish_job("timeout");
      chk("timeout_reads_lit", n_reads, 3);
      chk("timeout_err_lit", err, 1'b1);

      // Reset in the middle of DRAIN.
      setup_job(2'd2, 7, 1023, 1024, 0, 0);
      start_job(2'd2);
      cyc = 0;
      while (dst_seen < 100 && cyc < 10000) begin
         @(negedge axi_clk);
         cyc++;
      end
      chk("mid_reset_reach_drain", dst_seen >= 100, 1'b1);
      @(posedge axi_clk);
      #1;
      job_active = 0;
      axi_reset_n = 1'b0;
      @(negedge axi_clk);
      check_reset("mid_reset");
      rd_pend = 0;
      @(posedge axi_clk);
      #1;
      axi_reset_n = 1'b1;

      // Next job after reset; results 1,2,4 then zeros.
      setup_job(2'd2, 8, 1023, 1024, 0, 1);
      start_job(2'd2);
      finish_job("csum");
`ifdef NTT_HOST_CTRL_CHECKSUM_EN
      chk("csum_lit", checksum, 32'h7);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
